// File: rtl/scope_trigger_ctrl_if.sv
// Bundle of acquisition-side signals for scope_trigger_ctrl.
// master: the trigger controller (reads ADC samples and trigger settings,
//         drives the BRAM write port and the frame status).
// slave:  the surrounding logic (ADC front end, register block, BRAM).
// Signals:
//   data_in    packed samples, [W-1:0]=A, [2W-1:W]=B
//   trig_*     trigger level/hysteresis/edge/source/mode
//   pre_len    pre-trigger depth, arm one-cycle start request
//   wr_*       BRAM write port
//   trig_addr  trigger sample address, frame_done pulse, trig_forced, state_o
interface scope_trigger_ctrl_if #(
  parameter int unsigned W  = 14,
  parameter int unsigned AW = 10
);
  logic [2*W-1:0] data_in;
  logic [W-1:0]   trig_level;
  logic [W-2:0]   trig_hyst;
  logic           trig_edge;
  logic           trig_src;
  logic [1:0]     trig_mode;
  logic [AW-1:0]  pre_len;
  logic           arm;

  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [2*W-1:0] wr_data;
  logic [AW-1:0]  trig_addr;
  logic           frame_done;
  logic           trig_forced;
  logic [2:0]     state_o;

  modport master (
    input  data_in, trig_level, trig_hyst, trig_edge, trig_src, trig_mode, pre_len, arm,
    output wr_en, wr_addr, wr_data, trig_addr, frame_done, trig_forced, state_o
  );

  modport slave (
    output data_in, trig_level, trig_hyst, trig_edge, trig_src, trig_mode, pre_len, arm,
    input  wr_en, wr_addr, wr_data, trig_addr, frame_done, trig_forced, state_o
  );
endinterface

// File: rtl/scope_trigger_ctrl.sv
// Trigger and acquisition-window controller (ADC clock domain).
// Streams registered samples into a circular 2^AW buffer, keeps pre_len samples ahead
// of a hysteresis-qualified level/edge trigger, then freezes once a full frame is written
// and reports where the trigger sample landed.
// Ports:
//   clk    sample clock
//   reset  synchronous, active-high
//   bus    scope_trigger_ctrl_if.master: samples/settings in, BRAM write port and status out
module scope_trigger_ctrl #(
  parameter int unsigned W       = 14,
  parameter int unsigned AW      = 10,
  parameter int unsigned AUTO_TO = 1000000,
  parameter int unsigned HOLDOFF = 64
) (
  input logic                  clk,
  input logic                  reset,
  scope_trigger_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPre   = 3'd1,
    StArmed = 3'd2,
    StPost  = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [1:0] ModeAuto   = 2'b01;
  localparam logic [1:0] ModeSingle = 2'b10;
  localparam logic [1:0] ModeStop   = 2'b11;

  localparam logic [AW-1:0] PreMax = {{(AW-1){1'b1}}, 1'b0};
  localparam logic [W-1:0]  SMin   = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  SMax   = {1'b0, {(W-1){1'b1}}};

  state_e         state_q, state_d;
  logic [2*W-1:0] s_q;
  logic [AW-1:0]  wr_addr_q, pre_q, trig_addr_q;
  logic [31:0]    cnt_q;
  logic           primed_q, forced_q, done_q;

  logic signed [W-1:0] x, level, lo, hi;
  logic [W:0]          lo_raw, hi_raw;
  logic                fire, prime_hit, wr_en;
  logic [AW-1:0]       post_len;

  assign x      = bus.trig_src ? s_q[2*W-1:W] : s_q[W-1:0];
  assign level  = bus.trig_level;
  assign lo_raw = {level[W-1], level} - {2'b00, bus.trig_hyst};
  assign hi_raw = {level[W-1], level} + {2'b00, bus.trig_hyst};
  // The W+1 bit result leaves the W-bit range exactly when its top two bits disagree.
  assign lo     = (lo_raw[W] != lo_raw[W-1]) ? SMin : lo_raw[W-1:0];
  assign hi     = (hi_raw[W] != hi_raw[W-1]) ? SMax : hi_raw[W-1:0];

  assign prime_hit = bus.trig_edge ? (x > hi) : (x < lo);
  assign fire      = primed_q && (bus.trig_edge ? (x <= level) : (x >= level));

  assign wr_en    = (state_q == StPre) || (state_q == StArmed) || (state_q == StPost);
  // Trigger sample plus post_len samples complete the 2^AW frame.
  assign post_len = {AW{1'b1}} - pre_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.arm) state_d = StPre;
      StPre:   if (cnt_q + 32'd1 >= 32'(pre_q)) state_d = StArmed;
      StArmed: begin
        if (fire) begin
          state_d = StPost;
        end else if (bus.trig_mode == ModeAuto && cnt_q >= AUTO_TO - 1) begin
          state_d = StPost;
        end
      end
      StPost:  if (cnt_q == 32'(post_len) - 32'd1) state_d = StDone;
      StDone: begin
        if (bus.arm) begin
          state_d = StPre;
        end else if (bus.trig_mode != ModeSingle && cnt_q >= HOLDOFF - 1) begin
          state_d = StPre;
        end
      end
      default: state_d = StIdle;
    endcase
    // Stop overrides everything, including a frame about to complete.
    if (bus.trig_mode == ModeStop) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      s_q         <= '0;
      wr_addr_q   <= '0;
      pre_q       <= '0;
      trig_addr_q <= '0;
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      forced_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= bus.data_in;
      done_q  <= (state_q == StPost) && (state_d == StDone);
      if (wr_en) wr_addr_q <= wr_addr_q + AW'(1);

      // Per-state cycle counter; saturates so long waits never wrap.
      if (state_d != state_q) cnt_q <= '0;
      else if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;

      if (state_q == StArmed && state_d == StPost) begin
        trig_addr_q <= wr_addr_q;
        forced_q    <= !fire;
      end

      if (state_d == StPre && state_q != StPre) begin
        pre_q    <= (bus.pre_len > PreMax) ? PreMax : bus.pre_len;
        primed_q <= 1'b0;
      end else if (state_q == StArmed && fire) begin
        primed_q <= 1'b0;
      end else if ((state_q == StPre || state_q == StArmed) && prime_hit) begin
        primed_q <= 1'b1;
      end
    end
  end

  assign bus.wr_en       = wr_en;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = s_q;
  assign bus.trig_addr   = trig_addr_q;
  assign bus.frame_done  = done_q;
  assign bus.trig_forced = forced_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_scope_trigger_ctrl.sv
// Randomized bench for scope_trigger_ctrl with a cycle-level behavioural reference model.
module tb_scope_trigger_ctrl;
  localparam int unsigned W       = 14;
  localparam int unsigned AW      = 10;
  localparam int unsigned AUTO_TO = 1000;
  localparam int unsigned HOLDOFF = 64;
  localparam int          Depth   = 1 << AW;
  localparam int          SMinI   = -(1 << (W - 1));
  localparam int          SMaxI   = (1 << (W - 1)) - 1;

  typedef logic [W-1:0]  samp_t;
  typedef logic [W-2:0]  hyst_t;
  typedef logic [AW-1:0] addr_t;

  logic clk = 1'b0;
  logic reset;

  scope_trigger_ctrl_if #(.W(W), .AW(AW)) bus ();

  scope_trigger_ctrl #(
    .W      (W),
    .AW     (AW),
    .AUTO_TO(AUTO_TO),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 idle, 1 pre, 2 armed, 3 post, 4 done.
  int             m_phase, m_addr, m_pre, m_left, m_wait, m_hold, m_taddr;
  bit             m_primed, m_forced, m_done;
  logic [2*W-1:0] m_s;

  // Scenario configuration.
  logic [1:0] cfg_mode;
  int cfg_pat, cfg_per, cfg_amp, cfg_spike, cfg_arm_at;
  bit cfg_arm_rand, cfg_stop_post, cfg_reset_post;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sx(input samp_t v);
    return int'($signed(v));
  endfunction

  task automatic model_step();
    int  x, lv, lo, hi, nxt;
    bit  fire, prime, stop;
    if (reset) begin
      m_phase = 0; m_addr = 0; m_pre = 0; m_left = 0; m_wait = 0; m_hold = 0;
      m_taddr = 0; m_primed = 0; m_forced = 0; m_done = 0; m_s = '0;
    end else begin
      x  = bus.trig_src ? sx(m_s[2*W-1:W]) : sx(m_s[W-1:0]);
      lv = sx(bus.trig_level);
      lo = lv - int'(bus.trig_hyst);
      hi = lv + int'(bus.trig_hyst);
      if (lo < SMinI) lo = SMinI;
      if (hi > SMaxI) hi = SMaxI;
      fire  = m_primed && (bus.trig_edge ? (x <= lv) : (x >= lv));
      prime = bus.trig_edge ? (x > hi) : (x < lo);
      stop  = (bus.trig_mode == 2'b11);
      m_done = 0;
      nxt = m_phase;
      case (m_phase)
        0: if (bus.arm) nxt = 1;
        1: begin
          m_left--;
          if (m_left <= 0) nxt = 2;
        end
        2: begin
          m_wait++;
          if (fire) nxt = 3;
          else if (bus.trig_mode == 2'b01 && m_wait >= int'(AUTO_TO)) nxt = 3;
        end
        3: begin
          m_left--;
          if (m_left == 0) nxt = 4;
        end
        default: begin
          m_hold++;
          if (bus.arm) nxt = 1;
          else if (bus.trig_mode != 2'b10 && m_hold >= int'(HOLDOFF)) nxt = 1;
        end
      endcase
      if (m_phase == 2 && fire) m_primed = 0;
      else if ((m_phase == 1 || m_phase == 2) && prime) m_primed = 1;
      if (stop) nxt = 0;
      if (nxt != m_phase) begin
        case (nxt)
          1: begin
            m_pre    = (int'(bus.pre_len) > Depth - 2) ? Depth - 2 : int'(bus.pre_len);
            m_left   = (m_pre == 0) ? 1 : m_pre;
            m_primed = 0;
          end
          2: m_wait = 0;
          3: begin
            m_taddr  = m_addr;
            m_forced = !fire;
            m_left   = Depth - 1 - m_pre;
          end
          4: begin
            m_done = 1;
            m_hold = 0;
          end
          default: ;
        endcase
      end
      if (m_phase >= 1 && m_phase <= 3) m_addr = (m_addr + 1) % Depth;
      m_s     = bus.data_in;
      m_phase = nxt;
    end
  endtask

  task automatic check_outputs();
    check_eq("state", 32'(bus.state_o), 32'(m_phase));
    check_eq("wr_en", 32'(bus.wr_en), 32'(m_phase >= 1 && m_phase <= 3));
    check_eq("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
    check_eq("wr_data", 32'(bus.wr_data), 32'(m_s));
    check_eq("trig_addr", 32'(bus.trig_addr), 32'(m_taddr));
    check_eq("trig_forced", 32'(bus.trig_forced), 32'(m_forced));
    check_eq("frame_done", 32'(bus.frame_done), 32'(m_done));
    // A completed frame ends exactly where it started: trig_addr - pre_len.
    if (m_done) check_eq("frame_start", 32'(bus.wr_addr), 32'((m_taddr - m_pre) & (Depth - 1)));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  function automatic samp_t wave(input int t, input int chan);
    int v, ph, tt;
    tt = t + chan * (cfg_per / 3);
    case (cfg_pat)
      0: begin
        ph = tt % cfg_per;
        v  = (ph < cfg_per / 2) ? -cfg_amp + (4 * cfg_amp * ph) / cfg_per
                                : 3 * cfg_amp - (4 * cfg_amp * ph) / cfg_per;
      end
      1: v = 0;
      2: v = (t % 2 == 1) ? 10 : -10;
      3: v = int'($urandom_range(0, 16383)) - 8192;
      default: v = (chan == 0) ? t - cfg_amp : cfg_amp - t;
    endcase
    if (v < SMinI) v = SMinI;
    if (v > SMaxI) v = SMaxI;
    return samp_t'(v);
  endfunction

  task automatic setup(input logic [1:0] mode, input int pre, input int lvl, input int hyst,
                       input bit edge_f, input bit src, input int pat, input int per,
                       input int amp);
    bus.trig_mode  = mode;
    bus.pre_len    = addr_t'(pre);
    bus.trig_level = samp_t'(lvl);
    bus.trig_hyst  = hyst_t'(hyst);
    bus.trig_edge  = edge_f;
    bus.trig_src   = src;
    cfg_mode = mode; cfg_pat = pat; cfg_per = per; cfg_amp = amp;
    cfg_spike = -1; cfg_arm_at = -1;
    cfg_arm_rand = 0; cfg_stop_post = 0; cfg_reset_post = 0;
  endtask

  task automatic run(input int ncyc);
    bit    did_stop = 0;
    bit    did_rst  = 0;
    samp_t a;
    for (int t = 0; t < ncyc; t++) begin
      a = wave(t, 0);
      if (cfg_pat == 2 && t == cfg_spike) a = samp_t'(-20);
      bus.data_in   = {wave(t, 1), a};
      bus.arm       = (m_phase == 0) || (t == cfg_arm_at) ||
                      (cfg_arm_rand && $urandom_range(0, 499) == 0);
      bus.trig_mode = cfg_mode;
      reset         = 1'b0;
      if (cfg_stop_post && !did_stop && m_phase == 3 && m_left < 500) begin
        bus.trig_mode = 2'b11;
        did_stop      = 1;
      end
      if (cfg_reset_post && !did_rst && m_phase == 3 && m_left < 600) begin
        reset   = 1'b1;
        did_rst = 1;
      end
      step();
    end
    reset         = 1'b0;
    bus.arm       = 1'b0;
    bus.trig_mode = 2'b11;
    step();
    step();
  endtask

  initial begin
    int amp, r;
    bus.data_in = '0; bus.trig_level = '0; bus.trig_hyst = '0; bus.trig_edge = 1'b0;
    bus.trig_src = 1'b0; bus.trig_mode = 2'b00; bus.pre_len = '0; bus.arm = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Rising ramp through 0 with 256 pre-trigger samples.
    setup(2'b00, 256, 0, 16, 1'b0, 1'b0, 4, 100, 400);
    run(2500);
    // Alternating +/-10 never primes; a single -20 arms the next +10.
    setup(2'b00, 100, 0, 16, 1'b0, 1'b0, 2, 100, 0);
    cfg_spike = 5300;
    run(6500);
    // Auto mode on a flat input: forced triggers.
    setup(2'b01, 300, 0, 16, 1'b0, 1'b0, 1, 100, 0);
    run(3500);
    // Single mode holds DONE until a late arm.
    setup(2'b10, 512, 0, 50, 1'b0, 1'b0, 0, 300, 3000);
    cfg_arm_at = 11500;
    run(12000);
    // Stop mid-POST.
    setup(2'b00, 200, 0, 100, 1'b0, 1'b0, 0, 400, 4000);
    cfg_stop_post = 1;
    run(3000);
    // pre_len extremes.
    setup(2'b00, 1023, 300, 40, 1'b0, 1'b1, 0, 256, 2000);
    run(3000);
    setup(2'b00, 0, -200, 30, 1'b1, 1'b0, 0, 320, 2500);
    run(3000);
    // Falling edge on B, then reset during POST.
    setup(2'b00, 256, 500, 8, 1'b1, 1'b1, 4, 100, 1000);
    cfg_reset_post = 1;
    run(3000);

    for (int k = 0; k < 6; k++) begin
      amp = int'($urandom_range(200, 8191));
      r   = int'($urandom_range(0, 5));
      setup(2'($urandom_range(0, 2)),
            (r == 0) ? 0 : (r == 1) ? 1023 : int'($urandom_range(0, 1023)),
            int'($urandom_range(0, amp)) - amp / 2,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8191))
                                        : int'($urandom_range(0, amp / 8)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 3 : 0,
            int'($urandom_range(64, 700)), amp);
      cfg_arm_rand   = 1;
      cfg_stop_post  = ($urandom_range(0, 3) == 0);
      cfg_reset_post = ($urandom_range(0, 3) == 0);
      run(3500);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
